pool_layer: RTL and testbench
=============================

POOL_LAYER -- requirements
Module: pool_layer

Interface
REQ-001 Parameters (name, default, meaning): DATA_WIDTH 32 word width; IFM_SIZE 28 input map side; IFM_DEPTH 6 input maps; NUMBER_OF_UNITS 3 maps processed in parallel; IFM_SIZE_NEXT IFM_SIZE/2 output side; ADDRESS_SIZE_IFM $clog2(IFM_SIZE*IFM_SIZE); ADDRESS_SIZE_NEXT_IFM $clog2(IFM_SIZE_NEXT*IFM_SIZE_NEXT).
REQ-002 clk  in  1  single clock; all logic rising-edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 start_from_previous  in  1  one-cycle pulse: upstream conv buffer full.
REQ-005 end_to_previous  out  1  one-cycle pulse: upstream buffer fully read, may be overwritten.
REQ-006 ifm_enable_read_current  out  1  read strobe to upstream buffer.
REQ-007 ifm_address_read_current  out  ADDRESS_SIZE_IFM  row*IFM_SIZE+col.
REQ-008 ifm_sel_previous  out  $clog2(IFM_DEPTH/NUMBER_OF_UNITS+1)  channel-group select into upstream buffer.
REQ-009 data_in_from_previous1..3  in  DATA_WIDTH each  read data, valid one cycle after strobe.
REQ-010 ifm_enable_write_next, ifm_address_write_next (ADDRESS_SIZE_NEXT_IFM), data_out_for_next1..3 (DATA_WIDTH)  out  write port to next buffer.
REQ-011 ifm_sel_next  out  same width as ifm_sel_previous  group select into next buffer.
REQ-012 start_to_next  out  1  one-cycle pulse: next buffer complete. end_from_next  in  1  one-cycle pulse: next buffer released.

Function
REQ-013 2x2 window, stride 2, over IFM_DEPTH/NUMBER_OF_UNITS groups (default 2); each lane pools its own channel.
REQ-014 States IDLE, WAIT_NEXT, RD0, RD1, RD2, RD3, LAST, WR, DONE.
REQ-015 IDLE: on start_from_previous (or pending flag) -> WAIT_NEXT; WAIT_NEXT -> RD0 when next_busy is 0.
REQ-016 RD0..RD3 issue addresses (2r,2c),(2r,2c+1),(2r+1,2c),(2r+1,2c+1) with strobe high; LAST captures fourth datum; WR asserts write for one cycle at address r*IFM_SIZE_NEXT+c; exactly 6 cycles per output pixel.
REQ-017 Comparison is unsigned on the full word (inputs are post-ReLU non-negative; valid for both fixed and IEEE-754 positive values); first datum loads the running max.
REQ-018 Scan order c fastest, then r, then group; c, r, group counters wrap to 0 at IFM_SIZE_NEXT-1, IFM_SIZE_NEXT-1, last group respectively.
REQ-019 After WR of the final pixel of the final group: end_to_previous and start_to_next pulse in the same cycle, next_busy set, -> DONE -> IDLE next cycle.
REQ-020 next_busy clears on end_from_next; end_from_next and setting of next_busy in the same cycle -> next_busy stays set.
REQ-021 start_from_previous arriving while not IDLE sets a pending flag (single-depth), cleared on entry to WAIT_NEXT; second arrival while pending is ignored.
REQ-022 ifm_sel_previous and ifm_sel_next both equal the current group counter.

Reset
REQ-023 reset returns to IDLE within one cycle; all counters, pending, next_busy, running max, and every output are 0; mid-frame reset abandons the frame with no end_to_previous or start_to_next pulse.

Configuration
REQ-024 POOL_AVG_EN defined: average pooling -- 4 data summed in a DATA_WIDTH+2 accumulator, output = sum >> 2 truncated to DATA_WIDTH (fixed-point only); undefined: max pooling per REQ-017. Timing identical either way.

Structure
REQ-025 Package pool_pkg holds the state enum and default parameter constants.
REQ-026 One sub-module pool_window_reduce: 4-sample max (or average under POOL_AVG_EN) with load/accumulate/clear inputs, one per unit.

Verification
REQ-027 Ramp buffer (value = address) all groups, one start pulse -> output (r,c) = (2r+1)*28+2c+1; 392 writes; single end_to_previous/start_to_next pulse 2352 cycles after leaving WAIT_NEXT.
REQ-028 Window {5,9,2,7} lane1, {0,0,0,0} lane2, {0x3F800000,0x40000000,0,0} lane3 -> 9, 0, 0x40000000.
REQ-029 end_from_next withheld after frame 1, second start_from_previous -> held in WAIT_NEXT, no reads; end_from_next pulse -> reads begin next cycle.
REQ-030 start_from_previous pulsed twice mid-frame -> exactly one additional frame processed.
REQ-031 reset asserted at pixel 100 of group 0 -> outputs 0 next cycle, no handshake pulses; fresh start -> full correct frame.
REQ-032 POOL_AVG_EN build, window {4,8,12,16} -> output 10; window {1,1,1,2} -> 1.

Source files
------------

// File: rtl/pool_pkg.sv
// Shared definitions for the pooling layer.
// Holds the FSM state encoding, the default parameter values and a small
// width helper. The state constants are plain localparams so that older
// tools, and code that still compares against raw codes, accept them.
package pool_pkg;

  localparam int unsigned DATA_WIDTH_DEF      = 32;
  localparam int unsigned IFM_SIZE_DEF        = 28;
  localparam int unsigned IFM_DEPTH_DEF       = 6;
  localparam int unsigned NUMBER_OF_UNITS_DEF = 3;
  localparam int unsigned LANES               = 3;

  localparam int unsigned STATE_W = 4;
  typedef logic [STATE_W-1:0] pool_state_t;

  localparam logic [3:0] ST_IDLE      = 4'd0;
  localparam logic [3:0] ST_WAIT_NEXT = 4'd1;
  localparam logic [3:0] ST_RD0       = 4'd2;
  localparam logic [3:0] ST_RD1       = 4'd3;
  localparam logic [3:0] ST_RD2       = 4'd4;
  localparam logic [3:0] ST_RD3       = 4'd5;
  localparam logic [3:0] ST_LAST      = 4'd6;
  localparam logic [3:0] ST_WR        = 4'd7;
  localparam logic [3:0] ST_DONE      = 4'd8;

  // Counter width that stays legal (>= 1 bit) for tiny maps.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pool_window_reduce.sv
// One lane of the 2x2 window reduction.
// Default build: running unsigned maximum over the four samples.
// With POOL_AVG_EN defined: the four samples are summed in a two-bit wider
// accumulator and the result is the sum divided by four (truncated).
// Ports:
//   clk, reset   clock, synchronous active-high reset
//   clear        zero the accumulator
//   load         accumulator <= sample (first datum of a window)
//   accumulate   accumulator <= reduce(accumulator, sample)
//   sample       incoming datum
//   result_c     combinational reduce(accumulator, sample); valid as the
//                window result while the fourth datum is on sample
module pool_window_reduce import pool_pkg::*; #(
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clear,
  input  logic                  load,
  input  logic                  accumulate,
  input  logic [DATA_WIDTH-1:0] sample,
  output logic [DATA_WIDTH-1:0] result_c
);

`ifdef POOL_AVG_EN
  localparam int unsigned ACC_W = DATA_WIDTH + 2;
`else
  localparam int unsigned ACC_W = DATA_WIDTH;
`endif

  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] acc_op;

`ifdef POOL_AVG_EN
  // Sum cannot overflow: four DATA_WIDTH words fit in DATA_WIDTH+2 bits.
  always_comb begin
    acc_op   = acc + ACC_W'(sample);
    result_c = DATA_WIDTH'(acc_op >> 2);
  end
`else
  // Unsigned compare is order-preserving for non-negative fixed point and
  // for positive IEEE-754 values alike.
  always_comb begin
    acc_op   = (sample > acc) ? sample : acc;
    result_c = acc_op;
  end
`endif

  // Accumulator register.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      acc <= '0;
    end else if (load) begin
      acc <= ACC_W'(sample);
    end else if (accumulate) begin
      acc <= acc_op;
    end
  end

endmodule

// File: rtl/pool_layer.sv
// 2x2 / stride-2 pooling layer between a conv buffer (upstream) and the
// next layer's buffer (downstream). Three lanes pool three channels of the
// current channel group in parallel; groups are processed one after another.
// Each output pixel takes six cycles: four reads, a capture, one write.
// Optional feature: define POOL_AVG_EN for average pooling (max otherwise).
// Ports:
//   clk, reset                       clock, synchronous active-high reset
//   start_from_previous / end_to_previous   upstream frame handshake pulses
//   ifm_enable_read_current, ifm_address_read_current, ifm_sel_previous
//                                    upstream read port (data one cycle later)
//   data_in_from_previous1..3        upstream read data, one per lane
//   ifm_enable_write_next, ifm_address_write_next, ifm_sel_next,
//   data_out_for_next1..3            downstream write port
//   start_to_next / end_from_next    downstream frame handshake pulses
module pool_layer import pool_pkg::*; #(
  parameter int unsigned DATA_WIDTH            = DATA_WIDTH_DEF,
  parameter int unsigned IFM_SIZE              = IFM_SIZE_DEF,
  parameter int unsigned IFM_DEPTH             = IFM_DEPTH_DEF,
  parameter int unsigned NUMBER_OF_UNITS       = NUMBER_OF_UNITS_DEF,
  parameter int unsigned IFM_SIZE_NEXT         = IFM_SIZE / 2,
  parameter int unsigned ADDRESS_SIZE_IFM      = $clog2(IFM_SIZE * IFM_SIZE),
  parameter int unsigned ADDRESS_SIZE_NEXT_IFM = $clog2(IFM_SIZE_NEXT * IFM_SIZE_NEXT)
) (
  input  logic                                               clk,
  input  logic                                               reset,
  input  logic                                               start_from_previous,
  output logic                                               end_to_previous,
  output logic                                               ifm_enable_read_current,
  output logic [ADDRESS_SIZE_IFM-1:0]                        ifm_address_read_current,
  output logic [$clog2(IFM_DEPTH/NUMBER_OF_UNITS+1)-1:0]     ifm_sel_previous,
  input  logic [DATA_WIDTH-1:0]                              data_in_from_previous1,
  input  logic [DATA_WIDTH-1:0]                              data_in_from_previous2,
  input  logic [DATA_WIDTH-1:0]                              data_in_from_previous3,
  output logic                                               ifm_enable_write_next,
  output logic [ADDRESS_SIZE_NEXT_IFM-1:0]                   ifm_address_write_next,
  output logic [DATA_WIDTH-1:0]                              data_out_for_next1,
  output logic [DATA_WIDTH-1:0]                              data_out_for_next2,
  output logic [DATA_WIDTH-1:0]                              data_out_for_next3,
  output logic [$clog2(IFM_DEPTH/NUMBER_OF_UNITS+1)-1:0]     ifm_sel_next,
  output logic                                               start_to_next,
  input  logic                                               end_from_next
);

  localparam int unsigned GROUPS = IFM_DEPTH / NUMBER_OF_UNITS;
  localparam int unsigned SEL_W  = $clog2(GROUPS + 1);
  localparam int unsigned CNT_W  = cnt_width(IFM_SIZE_NEXT);

  pool_state_t      state, state_nx;
  logic [CNT_W-1:0] col, col_nx;
  logic [CNT_W-1:0] row, row_nx;
  logic [SEL_W-1:0] grp, grp_nx;
  logic             pending, pending_nx;
  logic             next_busy, next_busy_nx;

  logic                             rd_en_nx;
  logic [1:0]                       rd_phase;
  logic [ADDRESS_SIZE_IFM-1:0]      rd_addr_nx;
  logic                             wr_en_nx;
  logic [ADDRESS_SIZE_NEXT_IFM-1:0] wr_addr_nx;
  logic                             pulse_nx;
  logic                             red_clear, red_load, red_accum, capture;

  logic [DATA_WIDTH-1:0] din      [LANES];
  logic [DATA_WIDTH-1:0] result_c [LANES];
  logic [DATA_WIDTH-1:0] dout     [LANES];

  logic last_col, last_row, last_grp;

  assign din[0] = data_in_from_previous1;
  assign din[1] = data_in_from_previous2;
  assign din[2] = data_in_from_previous3;

  assign data_out_for_next1 = dout[0];
  assign data_out_for_next2 = dout[1];
  assign data_out_for_next3 = dout[2];

  assign ifm_sel_previous = grp;
  assign ifm_sel_next     = grp;

  assign last_col = (col == CNT_W'(IFM_SIZE_NEXT - 1));
  assign last_row = (row == CNT_W'(IFM_SIZE_NEXT - 1));
  assign last_grp = (grp == SEL_W'(GROUPS - 1));

  // One reduction unit per lane.
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    pool_window_reduce #(.DATA_WIDTH(DATA_WIDTH)) u_reduce (
      .clk        (clk),
      .reset      (reset),
      .clear      (red_clear),
      .load       (red_load),
      .accumulate (red_accum),
      .sample     (din[i]),
      .result_c   (result_c[i])
    );
  end

  // Next-state, counters and next values of every registered output.
  // Outputs are registered from the next state, so a strobe is visible in
  // the same cycle the FSM sits in the corresponding RD state.
  always_comb begin
    state_nx     = state;
    col_nx       = col;
    row_nx       = row;
    grp_nx       = grp;
    pending_nx   = pending;
    next_busy_nx = next_busy;
    rd_en_nx     = 1'b0;
    rd_phase     = 2'd0;
    rd_addr_nx   = '0;
    wr_en_nx     = 1'b0;
    wr_addr_nx   = '0;
    pulse_nx     = 1'b0;
    red_clear    = 1'b0;
    red_load     = 1'b0;
    red_accum    = 1'b0;
    capture      = 1'b0;

    if (end_from_next) next_busy_nx = 1'b0;
    if (start_from_previous && (state != ST_IDLE)) pending_nx = 1'b1;

    case (state)
      ST_IDLE: begin
        red_clear = 1'b1;
        if (start_from_previous || pending) begin
          state_nx   = ST_WAIT_NEXT;
          pending_nx = 1'b0;
        end
      end
      ST_WAIT_NEXT: begin
        // A release arriving this cycle lets the reads start immediately.
        if (!next_busy || end_from_next) begin
          state_nx = ST_RD0;
          rd_en_nx = 1'b1;
          rd_phase = 2'd0;
        end
      end
      ST_RD0: begin
        state_nx = ST_RD1;
        rd_en_nx = 1'b1;
        rd_phase = 2'd1;
      end
      ST_RD1: begin
        red_load = 1'b1;
        state_nx = ST_RD2;
        rd_en_nx = 1'b1;
        rd_phase = 2'd2;
      end
      ST_RD2: begin
        red_accum = 1'b1;
        state_nx  = ST_RD3;
        rd_en_nx  = 1'b1;
        rd_phase  = 2'd3;
      end
      ST_RD3: begin
        red_accum = 1'b1;
        state_nx  = ST_LAST;
      end
      ST_LAST: begin
        capture    = 1'b1;
        wr_en_nx   = 1'b1;
        wr_addr_nx = ADDRESS_SIZE_NEXT_IFM'(32'(row) * 32'(IFM_SIZE_NEXT) + 32'(col));
        state_nx   = ST_WR;
      end
      ST_WR: begin
        col_nx = last_col ? '0 : CNT_W'(col + 1'b1);
        if (last_col) begin
          row_nx = last_row ? '0 : CNT_W'(row + 1'b1);
          if (last_row) grp_nx = last_grp ? '0 : SEL_W'(grp + 1'b1);
        end
        if (last_col && last_row && last_grp) begin
          state_nx     = ST_DONE;
          pulse_nx     = 1'b1;
          next_busy_nx = 1'b1;
        end else begin
          state_nx = ST_RD0;
          rd_en_nx = 1'b1;
          rd_phase = 2'd0;
        end
      end
      ST_DONE: begin
        state_nx = ST_IDLE;
      end
      default: begin
        state_nx = ST_IDLE;
      end
    endcase

    // Window corner (2r+dr, 2c+dc), dr/dc taken from the read phase.
    if (rd_en_nx) begin
      rd_addr_nx = ADDRESS_SIZE_IFM'(
        (32'(row_nx) * 32'd2 + 32'(rd_phase[1])) * 32'(IFM_SIZE) +
        32'(col_nx) * 32'd2 + 32'(rd_phase[0]));
    end
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state                    <= ST_IDLE;
      col                      <= '0;
      row                      <= '0;
      grp                      <= '0;
      pending                  <= 1'b0;
      next_busy                <= 1'b0;
      ifm_enable_read_current  <= 1'b0;
      ifm_address_read_current <= '0;
      ifm_enable_write_next    <= 1'b0;
      ifm_address_write_next   <= '0;
      end_to_previous          <= 1'b0;
      start_to_next            <= 1'b0;
      for (int i = 0; i < LANES; i++) dout[i] <= '0;
    end else begin
      state                    <= state_nx;
      col                      <= col_nx;
      row                      <= row_nx;
      grp                      <= grp_nx;
      pending                  <= pending_nx;
      next_busy                <= next_busy_nx;
      ifm_enable_read_current  <= rd_en_nx;
      ifm_address_read_current <= rd_addr_nx;
      ifm_enable_write_next    <= wr_en_nx;
      ifm_address_write_next   <= wr_addr_nx;
      end_to_previous          <= pulse_nx;
      start_to_next            <= pulse_nx;
      for (int i = 0; i < LANES; i++) dout[i] <= capture ? result_c[i] : '0;
    end
  end

endmodule

// File: tb/tb_pool_layer.sv
// Self-checking bench for pool_layer (default parameters).
// An upstream buffer model answers reads one cycle after the strobe; a
// frame-level model predicts every read address and every written pixel.
module tb_pool_layer;

  localparam int S    = 28;
  localparam int SN   = 14;
  localparam int G    = 2;
  localparam int PPG  = SN * SN;
  localparam int NPIX = G * PPG;

  logic        clk = 1'b0;
  logic        reset;
  logic        start_from_previous;
  logic        end_to_previous;
  logic        ifm_enable_read_current;
  logic [9:0]  ifm_address_read_current;
  logic [1:0]  ifm_sel_previous;
  logic [31:0] data_in_from_previous1, data_in_from_previous2, data_in_from_previous3;
  logic        ifm_enable_write_next;
  logic [7:0]  ifm_address_write_next;
  logic [31:0] data_out_for_next1, data_out_for_next2, data_out_for_next3;
  logic [1:0]  ifm_sel_next;
  logic        start_to_next;
  logic        end_from_next;

  always #5 clk = ~clk;

  pool_layer dut (
    .clk                      (clk),
    .reset                    (reset),
    .start_from_previous      (start_from_previous),
    .end_to_previous          (end_to_previous),
    .ifm_enable_read_current  (ifm_enable_read_current),
    .ifm_address_read_current (ifm_address_read_current),
    .ifm_sel_previous         (ifm_sel_previous),
    .data_in_from_previous1   (data_in_from_previous1),
    .data_in_from_previous2   (data_in_from_previous2),
    .data_in_from_previous3   (data_in_from_previous3),
    .ifm_enable_write_next    (ifm_enable_write_next),
    .ifm_address_write_next   (ifm_address_write_next),
    .data_out_for_next1       (data_out_for_next1),
    .data_out_for_next2       (data_out_for_next2),
    .data_out_for_next3       (data_out_for_next3),
    .ifm_sel_next             (ifm_sel_next),
    .start_to_next            (start_to_next),
    .end_from_next            (end_from_next)
  );

  logic [31:0] mem [3][G][S*S];
  int vectors = 0, miscompares = 0;
  int cyc = 0;
  int idx = 0, rd_idx = 0;
  int wr_cnt = 0, rd_cnt = 0, done_cnt = 0, done_cyc = 0, first_rd_cyc = -1;
  logic [31:0] fw [3];
  logic [31:0] lw;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    vectors++;
    if (act !== exp_v) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", nm, act, exp_v, cyc);
    end
  endtask

  function automatic logic [31:0] pool4(input logic [31:0] a, b, c, d);
`ifdef POOL_AVG_EN
    logic [33:0] s;
    s = 34'(a) + 34'(b) + 34'(c) + 34'(d);
    return s[33:2];
`else
    logic [31:0] m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
`endif
  endfunction

  function automatic logic [31:0] exp_px(input int l, input int g, input int r, input int c);
    int b;
    b = (2 * r) * S + 2 * c;
    return pool4(mem[l][g][b], mem[l][g][b+1], mem[l][g][b+S], mem[l][g][b+S+1]);
  endfunction

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Upstream buffer: registered read, data one cycle after the strobe.
  initial begin
    logic en;
    int a, s;
    data_in_from_previous1 = '0;
    data_in_from_previous2 = '0;
    data_in_from_previous3 = '0;
    forever begin
      @(negedge clk);
      en = ifm_enable_read_current;
      a  = int'(ifm_address_read_current);
      s  = int'(ifm_sel_previous);
      @(posedge clk);
      #1;
      if (en) begin
        if (s < G && a < S * S) begin
          data_in_from_previous1 = mem[0][s][a];
          data_in_from_previous2 = mem[1][s][a];
          data_in_from_previous3 = mem[2][s][a];
        end else begin
          data_in_from_previous1 = 32'hDEAD_BEEF;
          data_in_from_previous2 = 32'hDEAD_BEEF;
          data_in_from_previous3 = 32'hDEAD_BEEF;
        end
      end
    end
  end

  // Compare process: every read and write against the frame model.
  initial forever begin
    int g, r, c, px, ph;
    @(negedge clk);
    if (ifm_enable_read_current) begin
      px = rd_idx / 4; ph = rd_idx % 4;
      g = px / PPG; r = (px % PPG) / SN; c = (px % PPG) % SN;
      check("rd_addr", 32'(ifm_address_read_current), 32'((2 * r + ph / 2) * S + 2 * c + ph % 2));
      check("rd_sel", 32'(ifm_sel_previous), 32'(g));
      rd_idx = (rd_idx + 1) % (NPIX * 4);
      rd_cnt++;
      if (first_rd_cyc < 0) first_rd_cyc = cyc;
    end
    if (ifm_enable_write_next) begin
      g = idx / PPG; r = (idx % PPG) / SN; c = (idx % PPG) % SN;
      check("wr_addr", 32'(ifm_address_write_next), 32'(r * SN + c));
      check("wr_sel", 32'(ifm_sel_next), 32'(g));
      check("wr_data1", data_out_for_next1, exp_px(0, g, r, c));
      check("wr_data2", data_out_for_next2, exp_px(1, g, r, c));
      check("wr_data3", data_out_for_next3, exp_px(2, g, r, c));
      if (idx == 0) begin
        fw[0] = data_out_for_next1; fw[1] = data_out_for_next2; fw[2] = data_out_for_next3;
      end
      if (idx == NPIX - 1) lw = data_out_for_next1;
      idx = (idx + 1) % NPIX;
      wr_cnt++;
    end
    if (end_to_previous || start_to_next)
      check("pulse_pair", 32'(end_to_previous), 32'(start_to_next));
    if (start_to_next) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  task automatic pulse_start();
    @(posedge clk); #1 start_from_previous = 1'b1;
    @(posedge clk); #1 start_from_previous = 1'b0;
  endtask

  task automatic pulse_release(output int at_cyc);
    @(posedge clk); #1 end_from_next = 1'b1;
    @(negedge clk); at_cyc = cyc;
    @(posedge clk); #1 end_from_next = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int d0, n;
    d0 = done_cnt; n = 0;
    while (done_cnt == d0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    check("frame_done", 32'(done_cnt > d0), 32'd1);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_rd_en"}, 32'(ifm_enable_read_current), 0);
    check({tag, "_rd_addr"}, 32'(ifm_address_read_current), 0);
    check({tag, "_sel_prev"}, 32'(ifm_sel_previous), 0);
    check({tag, "_wr_en"}, 32'(ifm_enable_write_next), 0);
    check({tag, "_wr_addr"}, 32'(ifm_address_write_next), 0);
    check({tag, "_sel_next"}, 32'(ifm_sel_next), 0);
    check({tag, "_dout1"}, data_out_for_next1, 0);
    check({tag, "_dout2"}, data_out_for_next2, 0);
    check({tag, "_dout3"}, data_out_for_next3, 0);
    check({tag, "_end_prev"}, 32'(end_to_previous), 0);
    check({tag, "_start_next"}, 32'(start_to_next), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w0, d0, r0, rel, x;
    reset = 1'b1;
    start_from_previous = 1'b0;
    end_from_next = 1'b0;
    for (int l = 0; l < 3; l++)
      for (int g = 0; g < G; g++)
        for (int a = 0; a < S * S; a++) mem[l][g][a] = a;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_outputs_zero("reset");
    @(posedge clk); #1 reset = 1'b0;

    // Hand-computed pins on the reference function itself.
`ifdef POOL_AVG_EN
    check("model_avg_a", pool4(32'd4, 32'd8, 32'd12, 32'd16), 32'd10);
    check("model_avg_b", pool4(32'd1, 32'd1, 32'd1, 32'd2), 32'd1);
`else
    check("model_max_a", pool4(32'd5, 32'd9, 32'd2, 32'd7), 32'd9);
    check("model_max_b", pool4(32'h3F80_0000, 32'h4000_0000, 0, 0), 32'h4000_0000);
`endif

    // Ramp frame: latency, write count, first/last pixel literals.
    w0 = wr_cnt; first_rd_cyc = -1;
    pulse_start();
    wait_done(3000);
    check("ramp_writes", 32'(wr_cnt - w0), 32'd392);
    check("ramp_latency", 32'(done_cyc - first_rd_cyc), 32'd2352);
`ifdef POOL_AVG_EN
    check("ramp_first", fw[0], 32'd14);
    check("ramp_last", lw, 32'd768);
`else
    check("ramp_first", fw[0], 32'd29);
    check("ramp_last", lw, 32'd783);
`endif
    pulse_release(rel);

    // Random frame with known windows at group 0, pixel (0,0).
    for (int l = 0; l < 3; l++)
      for (int g = 0; g < G; g++)
        for (int a = 0; a < S * S; a++) mem[l][g][a] = $urandom;
`ifdef POOL_AVG_EN
    mem[0][0][0] = 4; mem[0][0][1] = 8; mem[0][0][28] = 12; mem[0][0][29] = 16;
    mem[1][0][0] = 1; mem[1][0][1] = 1; mem[1][0][28] = 1;  mem[1][0][29] = 2;
`else
    mem[0][0][0] = 5; mem[0][0][1] = 9; mem[0][0][28] = 2;  mem[0][0][29] = 7;
    mem[1][0][0] = 0; mem[1][0][1] = 0; mem[1][0][28] = 0;  mem[1][0][29] = 0;
`endif
    mem[2][0][0] = 32'h3F80_0000; mem[2][0][1] = 32'h4000_0000;
    mem[2][0][28] = 0; mem[2][0][29] = 0;
    pulse_start();
    wait_done(3000);
`ifdef POOL_AVG_EN
    check("window_lane1", fw[0], 32'd10);
    check("window_lane2", fw[1], 32'd1);
    check("window_lane3", fw[2], 32'h1FE0_0000);
`else
    check("window_lane1", fw[0], 32'd9);
    check("window_lane2", fw[1], 32'd0);
    check("window_lane3", fw[2], 32'h4000_0000);
`endif

    // Downstream still busy: new frame must wait without reading.
    r0 = rd_cnt;
    pulse_start();
    repeat (40) @(posedge clk);
    check("no_reads_while_busy", 32'(rd_cnt - r0), 0);
    first_rd_cyc = -1;
    pulse_release(rel);
    repeat (5) @(posedge clk);
    check("reads_after_release", 32'(first_rd_cyc), 32'(rel + 1));

    // Two starts mid-frame collapse into one extra frame.
    repeat (600) @(posedge clk);
    pulse_start();
    repeat (300) @(posedge clk);
    pulse_start();
    wait_done(3000);
    pulse_release(rel);
    wait_done(3000);
    pulse_release(rel);
    d0 = done_cnt; r0 = rd_cnt;
    repeat (3000) @(posedge clk);
    check("no_third_frame_done", 32'(done_cnt - d0), 0);
    check("no_third_frame_reads", 32'(rd_cnt - r0), 0);

    // Reset at pixel 100 of group 0, then a fresh full frame.
    w0 = wr_cnt;
    pulse_start();
    x = 0;
    while (wr_cnt - w0 < 100 && x < 1000) begin
      @(posedge clk);
      x++;
    end
    check("reached_pixel_100", 32'(wr_cnt - w0), 32'd100);
    d0 = done_cnt;
    #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    idx = 0; rd_idx = 0;
    @(negedge clk);
    check_outputs_zero("midreset");
    repeat (50) @(posedge clk);
    check("no_pulse_after_reset", 32'(done_cnt - d0), 0);
    for (int l = 0; l < 3; l++)
      for (int g = 0; g < G; g++)
        for (int a = 0; a < S * S; a++) mem[l][g][a] = $urandom_range(0, 32'h7FFF_FFFF);
    w0 = wr_cnt;
    pulse_start();
    wait_done(3000);
    check("fresh_frame_writes", 32'(wr_cnt - w0), 32'd392);
    pulse_release(rel);
    repeat (10) @(posedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
